// File: rtl/beat_stim_pkg.sv
// Shared encodings and reset frequency words for the three-laser beat-note stimulus source.
package beat_stim_pkg;

  typedef enum logic [1:0] {
    OP_SET_FREQ   = 2'd0,
    OP_PHASE_STEP = 2'd1,
    OP_RAMP       = 2'd2,
    OP_CLR_PHASE  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  localparam logic [1:0] SEL_ALL = 2'd3;
  localparam int NUM_TONES = 3;

  // 13 / 7 / 4 MHz tones at a 125 MHz sample rate, floor(f * 2^32 / 125)
  localparam logic [31:0] DEF_F1_WORD = 32'd446676598;
  localparam logic [31:0] DEF_F2_WORD = 32'd240518168;
  localparam logic [31:0] DEF_F3_WORD = 32'd137438953;

endpackage

// File: rtl/beat_tone_stim_gen_tone_accum.sv
// One modelled laser: frequency word register plus free-running phase accumulator.
module tone_accum #(
  parameter int           W        = 32,
  parameter logic [W-1:0] RST_FREQ = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_en,
  input  logic         step_en,
  input  logic         inc_en,
  input  logic         clr_en,
  input  logic [W-1:0] cmd_val,
  input  logic [W-1:0] inc_val,
  output logic [W-1:0] freq,
  output logic [W-1:0] acc
);

  logic [W-1:0] freq_d, freq_q;
  logic [W-1:0] acc_d,  acc_q;

  always_comb begin
    freq_d = freq_q;
    if (set_en)      freq_d = cmd_val;
    else if (inc_en) freq_d = freq_q + inc_val;

    // a new frequency only takes effect on the accumulator one edge later
    acc_d = acc_q + freq_q;
    if (step_en) acc_d = acc_q + freq_q + cmd_val;
    if (clr_en)  acc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_q <= RST_FREQ;
      acc_q  <= '0;
    end else begin
      freq_q <= freq_d;
      acc_q  <= acc_d;
    end
  end

  assign freq = freq_q;
  assign acc  = acc_q;

endmodule

// File: rtl/beat_tone_stim_gen.sv
// Three-tone beat-note stimulus source: command decode, ramp FSM and registered beat outputs.
module beat_tone_stim_gen
  import beat_stim_pkg::*;
#(
  parameter int                     ACCUM_WIDTH = 32,
  parameter logic [ACCUM_WIDTH-1:0] F1_WORD     = ACCUM_WIDTH'(DEF_F1_WORD),
  parameter logic [ACCUM_WIDTH-1:0] F2_WORD     = ACCUM_WIDTH'(DEF_F2_WORD),
  parameter logic [ACCUM_WIDTH-1:0] F3_WORD     = ACCUM_WIDTH'(DEF_F3_WORD),
  parameter int                     LEN_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [1:0]             cmd_sel,
  input  logic [ACCUM_WIDTH-1:0] cmd_value,
  input  logic [LEN_W-1:0]       cmd_len,
  output logic [ACCUM_WIDTH-1:0] phase_a,
  output logic [ACCUM_WIDTH-1:0] phase_b,
  output logic [ACCUM_WIDTH-1:0] phase_c,
  output logic [ACCUM_WIDTH-1:0] fword_a,
  output logic [ACCUM_WIDTH-1:0] fword_b,
  output logic [ACCUM_WIDTH-1:0] fword_c,
  output logic [ACCUM_WIDTH-1:0] closure,
  output logic                   busy
);

  localparam logic [NUM_TONES-1:0][ACCUM_WIDTH-1:0] RST_FREQS = {F3_WORD, F2_WORD, F1_WORD};

  state_e                 state_d, state_q;
  logic [LEN_W-1:0]       cnt_d, cnt_q;
  logic [ACCUM_WIDTH-1:0] rinc_d, rinc_q;
  logic [1:0]             rsel_d, rsel_q;
  logic                   busy_d, busy_q;
  logic                   accept;
  op_e                    op;

  logic [NUM_TONES-1:0]                  set_en, step_en, inc_en, clr_en;
  logic [NUM_TONES-1:0][ACCUM_WIDTH-1:0] freq, acc;

  assign cmd_ready = (state_q == ST_IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign op        = op_e'(cmd_op);

  for (genvar i = 0; i < NUM_TONES; i++) begin : g_tone
    logic hit, rhit;
    assign hit        = (cmd_sel == SEL_ALL) || (cmd_sel == 2'(i));
    assign rhit       = (rsel_q  == SEL_ALL) || (rsel_q  == 2'(i));
    assign set_en[i]  = accept & hit & (op == OP_SET_FREQ);
    assign step_en[i] = accept & hit & (op == OP_PHASE_STEP);
    assign clr_en[i]  = accept & hit & (op == OP_CLR_PHASE);
    assign inc_en[i]  = (state_q == ST_RAMP) & rhit;

    tone_accum #(
      .W        (ACCUM_WIDTH),
      .RST_FREQ (RST_FREQS[i])
    ) u_tone (
      .clk     (clk),
      .rst     (rst),
      .set_en  (set_en[i]),
      .step_en (step_en[i]),
      .inc_en  (inc_en[i]),
      .clr_en  (clr_en[i]),
      .cmd_val (cmd_value),
      .inc_val (rinc_q),
      .freq    (freq[i]),
      .acc     (acc[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rinc_d  = rinc_q;
    rsel_d  = rsel_q;
    unique case (state_q)
      ST_IDLE: begin
        // a zero-length ramp is consumed without leaving IDLE
        if (accept && (op == OP_RAMP) && (cmd_len != '0)) begin
          state_d = ST_RAMP;
          cnt_d   = cmd_len;
          rinc_d  = cmd_value;
          rsel_d  = cmd_sel;
        end
      end
      ST_RAMP: begin
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RAMP);
  end

  logic [ACCUM_WIDTH-1:0] phase_a_d, phase_b_d, phase_c_d, closure_d;
  logic [ACCUM_WIDTH-1:0] phase_a_q, phase_b_q, phase_c_q, closure_q;
  logic [ACCUM_WIDTH-1:0] fword_a_q, fword_b_q, fword_c_q;

  always_comb begin
    phase_a_d = acc[0] - acc[1];
    phase_b_d = acc[0] - acc[2];
    phase_c_d = acc[1] - acc[2];
    // built from the same snapshot, so any nonzero value exposes a datapath fault
    closure_d = phase_a_d - phase_b_d + phase_c_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rinc_q    <= '0;
      rsel_q    <= '0;
      busy_q    <= 1'b0;
      phase_a_q <= '0;
      phase_b_q <= '0;
      phase_c_q <= '0;
      closure_q <= '0;
      fword_a_q <= '0;
      fword_b_q <= '0;
      fword_c_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rinc_q    <= rinc_d;
      rsel_q    <= rsel_d;
      busy_q    <= busy_d;
      phase_a_q <= phase_a_d;
      phase_b_q <= phase_b_d;
      phase_c_q <= phase_c_d;
      closure_q <= closure_d;
      fword_a_q <= freq[0] - freq[1];
      fword_b_q <= freq[0] - freq[2];
      fword_c_q <= freq[1] - freq[2];
    end
  end

  assign phase_a = phase_a_q;
  assign phase_b = phase_b_q;
  assign phase_c = phase_c_q;
  assign closure = closure_q;
  assign fword_a = fword_a_q;
  assign fword_b = fword_b_q;
  assign fword_c = fword_c_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_beat_tone_stim_gen.sv
// Scoreboard bench: the stimulus thread predicts each edge in the beat domain, a negedge monitor checks.
module tb_beat_tone_stim_gen;

  localparam logic [31:0] F1 = 32'd446676598;
  localparam logic [31:0] F2 = 32'd240518168;
  localparam logic [31:0] F3 = 32'd137438953;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_sel = 2'd0;
  logic [31:0] cmd_value = '0;
  logic [15:0] cmd_len = '0;
  logic [31:0] phase_a, phase_b, phase_c, fword_a, fword_b, fword_c, closure;
  logic        busy;

  beat_tone_stim_gen dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_value(cmd_value), .cmd_len(cmd_len),
    .phase_a(phase_a), .phase_b(phase_b), .phase_c(phase_c),
    .fword_a(fword_a), .fword_b(fword_b), .fword_c(fword_c),
    .closure(closure), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pa, pb, pc, fa, fb, fc;
    logic        rdy, bsy;
  } rec_t;

  rec_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_n = 0;

  // reference state: tone frequency words plus beat-domain phases
  logic [31:0] t1 = F1, t2 = F2, t3 = F3;
  logic [31:0] pa = '0, pb = '0, pc = '0;
  int          ramp_left = 0;
  logic [1:0]  rsel = '0;
  logic [31:0] rinc = '0;
  logic        last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%h exp=%h", name, edge_n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      edge_n++;
      chk("phase_a", phase_a, e.pa);
      chk("phase_b", phase_b, e.pb);
      chk("phase_c", phase_c, e.pc);
      chk("fword_a", fword_a, e.fa);
      chk("fword_b", fword_b, e.fb);
      chk("fword_c", fword_c, e.fc);
      chk("closure", closure, 32'd0);
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e.rdy});
      chk("busy", {31'd0, busy}, {31'd0, e.bsy});
    end
  end

  task automatic cyc();
    rec_t r;
    @(posedge clk);
    last_acc = 1'b0;
    r = '{default: '0};
    if (rst) begin
      t1 = F1; t2 = F2; t3 = F3;
      pa = '0; pb = '0; pc = '0;
      ramp_left = 0;
    end else begin
      r.pa = pa; r.pb = pb; r.pc = pc;
      r.fa = t1 - t2; r.fb = t1 - t3; r.fc = t2 - t3;
      pa = pa + r.fa; pb = pb + r.fb; pc = pc + r.fc;
      if (ramp_left > 0) begin
        if (rsel == 2'd0 || rsel == 2'd3) t1 = t1 + rinc;
        if (rsel == 2'd1 || rsel == 2'd3) t2 = t2 + rinc;
        if (rsel == 2'd2 || rsel == 2'd3) t3 = t3 + rinc;
        ramp_left--;
      end else if (cmd_valid) begin
        last_acc = 1'b1;
        case (cmd_op)
          2'd0: begin
            if (cmd_sel == 2'd0 || cmd_sel == 2'd3) t1 = cmd_value;
            if (cmd_sel == 2'd1 || cmd_sel == 2'd3) t2 = cmd_value;
            if (cmd_sel == 2'd2 || cmd_sel == 2'd3) t3 = cmd_value;
          end
          2'd1: case (cmd_sel)
            2'd0: begin pa = pa + cmd_value; pb = pb + cmd_value; end
            2'd1: begin pa = pa - cmd_value; pc = pc + cmd_value; end
            2'd2: begin pb = pb - cmd_value; pc = pc - cmd_value; end
            default: ;
          endcase
          2'd2: if (cmd_len != 0) begin
            ramp_left = int'(cmd_len); rsel = cmd_sel; rinc = cmd_value;
          end
          default: if (cmd_sel == 2'd3) begin pa = '0; pb = '0; pc = '0; end
        endcase
      end
      r.rdy = (ramp_left == 0);
      r.bsy = (ramp_left > 0);
    end
    q.push_back(r);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] sel,
                      input logic [31:0] val, input logic [15:0] len);
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_value = val; cmd_len = len;
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (10) cyc();                          // free-running beats
    send(2'd0, 2'd1, 32'd0, 16'd0);             // tone 2 frequency to zero
    repeat (4) cyc();
    send(2'd1, 2'd0, 32'h4000_0000, 16'd0);     // phase step on tone 1
    repeat (4) cyc();
    send(2'd2, 2'd2, 32'd1000, 16'd100);        // 100-cycle ramp on tone 3
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_sel = 2'd1; cmd_value = 32'h0000_0123;
    n = 0;
    do begin cyc(); n++; end while (!last_acc && n < 200);
    cmd_valid = 1'b0;
    tests++;
    if (n != 101) begin
      fails++;
      $display("FAIL held_cmd_accept cycles=%0d exp=101", n);
    end
    repeat (3) cyc();
    send(2'd2, 2'd1, 32'd7, 16'd0);             // zero-length ramp is discarded
    send(2'd1, 2'd3, 32'h1234_5678, 16'd0);     // common step leaves beats alone
    repeat (3) cyc();
    send(2'd3, 2'd3, 32'd0, 16'd0);             // clear all phases
    repeat (3) cyc();
    send(2'd2, 2'd0, 32'd5, 16'd100);           // ramp aborted by reset
    repeat (49) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (5) cyc();
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
